// File: rtl/line_obstacle_sequencer_pkg.sv
// Shared constants and state encoding for the Wild Cube line-obstacle sequencer.
// N_LINES is also used by the top level and by the line instances.
package line_obstacle_sequencer_pkg;

    localparam int N_LINES        = 5;
    localparam int STAGGER_FRAMES = 30;
    localparam int FLASH_HALF     = 15;
    localparam int HIT_FRAMES     = 120;
    localparam int ARM_FRAMES     = 2;

    localparam logic [2:0] LIVES         = 3'd3;
    localparam logic [3:0] FLASH_HALF_M1 = 4'(FLASH_HALF - 1);
    localparam logic [7:0] HIT_TERM      = 8'(HIT_FRAMES);
    localparam logic [7:0] ARM_TERM      = 8'(ARM_FRAMES);
    localparam logic [7:0] SCORE_MAX     = 8'd255;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_PLAY = 3'd2,
        S_HIT  = 3'd3,
        S_OVER = 3'd4
    } state_t;

endpackage

// File: rtl/line_obstacle_sequencer_frame_timer.sv
// Frame-pulse counter with clear, terminal-count detect and a flash half-period toggle.
// o_done and o_toggle are combinational strobes, valid in the cycle of the counted frame pulse.
module line_obstacle_sequencer_frame_timer
    import line_obstacle_sequencer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_clear,
    input  logic       i_frame,
    input  logic [7:0] i_terminal,
    output logic       o_done,
    output logic       o_toggle
);

    logic [7:0] r_count;
    logic [3:0] r_half;

    assign o_done   = i_frame && (r_count == (i_terminal - 8'd1));
    assign o_toggle = i_frame && (r_half == FLASH_HALF_M1);

    // Clear wins over a coincident frame pulse, so that pulse is never counted.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= 8'd0;
            r_half  <= 4'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
            r_half  <= 4'd0;
        end else if (i_frame) begin
            r_count <= r_count + 8'd1;
            r_half  <= o_toggle ? 4'd0 : r_half + 4'd1;
        end
    end

endmodule

// File: rtl/line_obstacle_sequencer.sv
// Game-flow controller for the moving line obstacles: launch staggering,
// freeze-and-flash on collision, lives and score. All outputs are registered.
module line_obstacle_sequencer
    import line_obstacle_sequencer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_frame,
    input  logic               i_btn_start,
    input  logic               i_collide,
    input  logic               i_lane_pass,
    output logic [N_LINES-1:0] o_start_machine,
    output logic               o_load_counter,
    output logic               o_flash,
    output logic               o_stop,
    output logic [7:0]         o_score,
    output logic [2:0]         o_lives_left,
    output logic [2:0]         o_game_state
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_btn_q;
    logic [N_LINES-1:0] r_mask;
    logic [7:0]         r_launch;
    logic               r_load;
    logic               r_flash;
    logic               r_stop;
    logic [7:0]         r_score;
    logic [2:0]         r_lives;

    logic               w_btn_rise;
    logic               w_state_change;
    logic [7:0]         w_terminal;
    logic               w_done;
    logic               w_toggle;
    logic               w_launch_inc;
    logic [7:0]         w_launch_next;
    logic [N_LINES-1:0] w_due;

    assign w_btn_rise     = i_btn_start && !r_btn_q;
    assign w_state_change = (w_state_next != r_state);
    assign w_terminal     = (r_state == S_HIT) ? HIT_TERM : ARM_TERM;

    line_obstacle_sequencer_frame_timer u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clear    (w_state_change),
        .i_frame    (i_frame),
        .i_terminal (w_terminal),
        .o_done     (w_done),
        .o_toggle   (w_toggle)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_btn_rise) w_state_next = S_ARM;
            S_ARM:   if (w_done) w_state_next = S_PLAY;
            S_PLAY:  if (i_collide) w_state_next = S_HIT;
            S_HIT:   if (w_done) w_state_next = (r_lives == 3'd0) ? S_OVER : S_PLAY;
            S_OVER:  if (w_btn_rise) w_state_next = S_ARM;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Launch count survives HIT and stops advancing once every line is running.
    always_comb begin
        w_launch_inc  = i_frame && (r_state == S_PLAY) && !w_state_change && !(&r_mask);
        w_launch_next = r_launch + {7'd0, w_launch_inc};
        w_due         = '0;
        for (int k = 0; k < N_LINES; k++) begin
            w_due[k] = (w_launch_next >= 8'(k * STAGGER_FRAMES));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_btn_q  <= 1'b0;
            r_mask   <= '0;
            r_launch <= 8'd0;
            r_load   <= 1'b1;
            r_flash  <= 1'b1;
            r_stop   <= 1'b0;
            r_score  <= 8'd0;
            r_lives  <= LIVES;
        end else begin
            r_state <= w_state_next;
            r_btn_q <= i_btn_start;
            case (w_state_next)
                S_IDLE: begin
                    r_load  <= 1'b1;
                    r_stop  <= 1'b0;
                    r_flash <= r_flash ^ w_toggle;
                end
                S_ARM: begin
                    r_load   <= 1'b1;
                    r_stop   <= 1'b1;
                    r_flash  <= 1'b1;
                    r_mask   <= '0;
                    r_launch <= 8'd0;
                    if (r_state != S_ARM) begin
                        r_score <= 8'd0;
                        r_lives <= LIVES;
                    end
                end
                S_PLAY: begin
                    r_load   <= 1'b0;
                    r_stop   <= 1'b1;
                    r_flash  <= 1'b1;
                    r_mask   <= r_mask | w_due;
                    r_launch <= w_launch_next;
                    if (r_state == S_PLAY && i_lane_pass && r_score != SCORE_MAX)
                        r_score <= r_score + 8'd1;
                end
                S_HIT: begin
                    r_load <= 1'b0;
                    r_stop <= 1'b0;
                    if (r_state == S_PLAY) begin
                        r_lives <= r_lives - 3'd1;
                        r_flash <= 1'b0;
                    end else begin
                        r_flash <= r_flash ^ w_toggle;
                    end
                end
                S_OVER: begin
                    r_load  <= 1'b1;
                    r_stop  <= 1'b0;
                    r_mask  <= '0;
                    r_flash <= r_flash ^ w_toggle;
                end
                default: begin
                    r_load <= 1'b1;
                    r_stop <= 1'b0;
                end
            endcase
        end
    end

    assign o_start_machine = r_mask;
    assign o_load_counter  = r_load;
    assign o_flash         = r_flash;
    assign o_stop          = r_stop;
    assign o_score         = r_score;
    assign o_lives_left    = r_lives;
    assign o_game_state    = r_state;

endmodule

// File: tb/tb_line_obstacle_sequencer.sv
// Directed bench for line_obstacle_sequencer: the driver queues hand-computed
// output snapshots and raises a sample strobe; the monitor pops and compares on the falling edge.
module tb_line_obstacle_sequencer;
    import line_obstacle_sequencer_pkg::*;

    localparam int W = 22;

    logic               clk;
    logic               reset_n;
    logic               frame;
    logic               btn_start;
    logic               collide;
    logic               lane_pass;
    logic [N_LINES-1:0] start_machine;
    logic               load_counter;
    logic               flash;
    logic               stop;
    logic [7:0]         score;
    logic [2:0]         lives_left;
    logic [2:0]         game_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    string        tag_q[$];
    logic         chk_req;
    int           n_checks;
    int           n_errors;

    // Snapshot layout: {start[4:0], load, flash, stop, score[7:0], lives[2:0], state[2:0]}
    localparam logic [W-1:0] M_ALL   = '1;
    localparam logic [W-1:0] M_NOFL  = ~(22'(1) << 15);

    line_obstacle_sequencer dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_frame         (frame),
        .i_btn_start     (btn_start),
        .i_collide       (collide),
        .i_lane_pass     (lane_pass),
        .o_start_machine (start_machine),
        .o_load_counter  (load_counter),
        .o_flash         (flash),
        .o_stop          (stop),
        .o_score         (score),
        .o_lives_left    (lives_left),
        .o_game_state    (game_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input logic [4:0] st_m, input logic ld, input logic fl,
                                        input logic sp, input logic [7:0] sc,
                                        input logic [2:0] lv, input logic [2:0] gs);
        return {st_m, ld, fl, sp, sc, lv, gs};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            tick();
            tick();
            tick();
        end
    endtask

    task automatic lanes(input int n);
        for (int i = 0; i < n; i++) begin
            lane_pass = 1'b1;
            tick();
            lane_pass = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_collide();
        collide = 1'b1;
        tick();
        collide = 1'b0;
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
    endtask

    task automatic chk(input string name, input logic [W-1:0] e, input logic [W-1:0] m);
        exp_q.push_back(e);
        msk_q.push_back(m);
        tag_q.push_back(name);
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (chk_req) begin
            logic [W-1:0] act;
            logic [W-1:0] e;
            logic [W-1:0] m;
            string        t;
            act = {start_machine, load_counter, flash, stop, score, lives_left, game_state};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL monitor: sample strobe with empty expected queue, got %h", act);
            end else begin
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                t = tag_q.pop_front();
                if ((act & m) !== (e & m)) begin
                    n_errors++;
                    $display("FAIL %s: got start=%b load=%b flash=%b stop=%b score=%0d lives=%0d state=%0d, expected start=%b load=%b flash=%b stop=%b score=%0d lives=%0d state=%0d (mask %h)",
                             t, act[21:17], act[16], act[15], act[14], act[13:6], act[5:3], act[2:0],
                             e[21:17], e[16], e[15], e[14], e[13:6], e[5:3], e[2:0], m);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (60000) @(posedge clk);
        n_errors++;
        $display("FAIL watchdog: cycle budget of 60000 exceeded, required directed sequence to finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        chk_req   = 1'b0;
        reset_n   = 1'b0;
        frame     = 1'b0;
        btn_start = 1'b0;
        collide   = 1'b0;
        lane_pass = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("reset", pk(5'b00000, 1, 1, 0, 0, 3, S_IDLE), M_ALL);

        frames(14);
        chk("idle_f14", pk(5'b00000, 1, 1, 0, 0, 3, S_IDLE), M_ALL);
        frames(1);
        chk("idle_f15", pk(5'b00000, 1, 0, 0, 0, 3, S_IDLE), M_ALL);
        frames(15);
        chk("idle_f30", pk(5'b00000, 1, 1, 0, 0, 3, S_IDLE), M_ALL);
        frames(10);
        chk("idle_f40", pk(5'b00000, 1, 1, 0, 0, 3, S_IDLE), M_ALL);

        btn_start = 1'b1;
        tick();
        chk("arm_entry", pk(5'b00000, 1, 1, 1, 0, 3, S_ARM), M_NOFL);
        frames(1);
        chk("arm_f1_held_btn", pk(5'b00000, 1, 1, 1, 0, 3, S_ARM), M_NOFL);
        btn_start = 1'b0;
        frames(1);
        chk("play_entry", pk(5'b00001, 0, 1, 1, 0, 3, S_PLAY), M_ALL);

        frames(29);
        chk("play_f29", pk(5'b00001, 0, 1, 1, 0, 3, S_PLAY), M_ALL);
        frames(1);
        chk("play_f30", pk(5'b00011, 0, 1, 1, 0, 3, S_PLAY), M_ALL);
        frames(59);
        chk("play_f89", pk(5'b00111, 0, 1, 1, 0, 3, S_PLAY), M_ALL);
        frames(30);
        chk("play_f119", pk(5'b01111, 0, 1, 1, 0, 3, S_PLAY), M_ALL);
        frames(1);
        chk("play_f120", pk(5'b11111, 0, 1, 1, 0, 3, S_PLAY), M_ALL);

        press_start();
        tick();
        chk("btn_in_play", pk(5'b11111, 0, 1, 1, 0, 3, S_PLAY), M_ALL);

        frames(10);
        pulse_collide();
        chk("hit1_entry", pk(5'b11111, 0, 0, 0, 0, 2, S_HIT), M_ALL);
        frames(119);
        chk("hit1_f119", pk(5'b11111, 0, 1, 0, 0, 2, S_HIT), M_NOFL);
        frames(1);
        chk("hit1_resume", pk(5'b11111, 0, 1, 1, 0, 2, S_PLAY), M_ALL);

        lanes(7);
        chk("score7", pk(5'b11111, 0, 1, 1, 7, 2, S_PLAY), M_ALL);
        collide   = 1'b1;
        lane_pass = 1'b1;
        tick();
        collide   = 1'b0;
        lane_pass = 1'b0;
        chk("collide_and_lane", pk(5'b11111, 0, 0, 0, 7, 1, S_HIT), M_ALL);
        lanes(1);
        pulse_collide();
        frames(120);
        chk("hit2_resume_lane_ignored", pk(5'b11111, 0, 1, 1, 7, 1, S_PLAY), M_ALL);

        lanes(247);
        chk("score254", pk(5'b11111, 0, 1, 1, 254, 1, S_PLAY), M_ALL);
        lanes(1);
        chk("score255", pk(5'b11111, 0, 1, 1, 255, 1, S_PLAY), M_ALL);
        lanes(8);
        chk("score_sat", pk(5'b11111, 0, 1, 1, 255, 1, S_PLAY), M_ALL);

        pulse_collide();
        chk("hit3_entry", pk(5'b11111, 0, 0, 0, 255, 0, S_HIT), M_ALL);
        frames(120);
        chk("over", pk(5'b00000, 1, 0, 0, 255, 0, S_OVER), M_NOFL);
        pulse_collide();
        tick();
        chk("collide_in_over", pk(5'b00000, 1, 0, 0, 255, 0, S_OVER), M_NOFL);

        press_start();
        chk("restart_arm", pk(5'b00000, 1, 1, 1, 0, 3, S_ARM), M_NOFL);
        frames(2);
        chk("restart_play", pk(5'b00001, 0, 1, 1, 0, 3, S_PLAY), M_ALL);
        frames(40);
        pulse_collide();
        frames(5);
        chk("hit_before_reset", pk(5'b00011, 0, 0, 0, 0, 2, S_HIT), M_NOFL);

        tick();
        #2;
        reset_n = 1'b0;
        chk("async_reset", pk(5'b00000, 1, 1, 0, 0, 3, S_IDLE), M_ALL);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("after_release", pk(5'b00000, 1, 1, 0, 0, 3, S_IDLE), M_ALL);

        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
